// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, drives prefetch FIFO shift/clear and
// registers accepted instructions (16- or 32-bit) toward decode.
module instr_fetch #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [XLEN-1:0]  pc_ff_o,
  output logic             instr_req_o,
  output logic             clear_o,
  input  logic             pf_stall_i,
  input  logic             pf_ack_i,
  input  logic [31:0]      pf_instr_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             id_ready_i,
  output logic             if2id_valid_o,
  output logic [31:0]      if2id_instr_o,
  output logic [XLEN-1:0]  if2id_pc_o,
  output logic             if2id_compressed_o
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [XLEN-1:0] INC_C    = XLEN'(2);
  localparam logic [XLEN-1:0] INC_W    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_HW = {{(XLEN-1){1'b1}}, 1'b0};

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   out_pc_q, out_pc_d;
  logic              comp_q, comp_d;
  logic              take_s;
  logic              is_comp_s;
  logic              req_s;

  // Next-state, output-register and FIFO-request logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    out_pc_d  = out_pc_q;
    comp_d    = comp_q;
    req_s     = 1'b0;
    is_comp_s = (pf_instr_i[1:0] != 2'b11);
    take_s    = (state_q == RUN) & pf_ack_i & ~pf_stall_i & (~valid_q | id_ready_i);

    if (redirect_i) begin
      // Redirect wins over everything; a coincident word is dropped.
      pc_d    = redirect_pc_i & ALIGN_HW;
      valid_d = 1'b0;
      state_d = FILL;
    end else begin
      case (state_q)
        FILL: begin
          req_s = pf_stall_i;
          if (!pf_stall_i) begin
            state_d = RUN;
          end else begin
            state_d = FILL;
          end
        end
        RUN: begin
          req_s = take_s;
          if (pf_stall_i) begin
            state_d = FILL;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase

      if (take_s) begin
        comp_d   = is_comp_s;
        instr_d  = is_comp_s ? {16'h0000, pf_instr_i[15:0]} : pf_instr_i;
        out_pc_d = pc_q;
        valid_d  = 1'b1;
        pc_d     = pc_q + (is_comp_s ? INC_C : INC_W);
      end else if (id_ready_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d = valid_q;
      end
    end
  end

  // State, PC and decode output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= 32'h0000_0000;
      out_pc_q <= '0;
      comp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      out_pc_q <= out_pc_d;
      comp_q   <= comp_d;
    end
  end

  assign pc_ff_o            = pc_q;
  assign instr_req_o        = req_s & ~rst;
  assign clear_o            = rst | redirect_i;
  assign if2id_valid_o      = valid_q;
  assign if2id_instr_o      = instr_q;
  assign if2id_pc_o         = out_pc_q;
  assign if2id_compressed_o = comp_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus random stimulus for instr_fetch, checked against a
// cycle-level behavioural model of the fetch rules.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_ff_o;
  logic        instr_req_o;
  logic        clear_o;
  logic        pf_stall_i;
  logic        pf_ack_i;
  logic [31:0] pf_instr_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        if2id_valid_o;
  logic [31:0] if2id_instr_o;
  logic [31:0] if2id_pc_o;
  logic        if2id_compressed_o;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_fill;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pco;
  logic        m_comp;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_ff_o           (pc_ff_o),
    .instr_req_o       (instr_req_o),
    .clear_o           (clear_o),
    .pf_stall_i        (pf_stall_i),
    .pf_ack_i          (pf_ack_i),
    .pf_instr_i        (pf_instr_i),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .id_ready_i        (id_ready_i),
    .if2id_valid_o     (if2id_valid_o),
    .if2id_instr_o     (if2id_instr_o),
    .if2id_pc_o        (if2id_pc_o),
    .if2id_compressed_o(if2id_compressed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h8000_0000;
    m_fill  = 1'b1;
    m_valid = 1'b0;
    m_instr = 32'h0;
    m_pco   = 32'h0;
    m_comp  = 1'b0;
  endtask

  // One clock cycle; called just after a falling edge.
  task automatic step(input logic st, input logic ak, input logic [31:0] ins,
                      input logic rd, input logic [31:0] tg, input logic rdy);
    logic mtake;
    logic exp_req;
    pf_stall_i    = st;
    pf_ack_i      = ak;
    pf_instr_i    = ins;
    redirect_i    = rd;
    redirect_pc_i = tg;
    id_ready_i    = rdy;
    #1;
    mtake   = !m_fill && ak && !st && (!m_valid || rdy);
    exp_req = rd ? 1'b0 : (m_fill ? st : mtake);
    chk("instr_req", {31'h0, instr_req_o}, {31'h0, exp_req});
    chk("clear", {31'h0, clear_o}, {31'h0, rd});
    @(posedge clk);
    if (rd) begin
      m_pc    = {tg[31:1], 1'b0};
      m_valid = 1'b0;
      m_fill  = 1'b1;
    end else if (m_fill) begin
      if (!st) m_fill = 1'b0;
      if (rdy) m_valid = 1'b0;
    end else begin
      if (mtake) begin
        m_comp  = (ins[1:0] != 2'b11);
        m_instr = m_comp ? {16'h0000, ins[15:0]} : ins;
        m_pco   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + (m_comp ? 32'd2 : 32'd4);
      end else if (rdy) begin
        m_valid = 1'b0;
      end
      if (st) m_fill = 1'b1;
    end
    #1;
    chk("pc_ff", pc_ff_o, m_pc);
    chk("valid", {31'h0, if2id_valid_o}, {31'h0, m_valid});
    chk("out_instr", if2id_instr_o, m_instr);
    chk("out_pc", if2id_pc_o, m_pco);
    chk("out_comp", {31'h0, if2id_compressed_o}, {31'h0, m_comp});
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] ins;
    rst = 1'b1;
    pf_stall_i = 1'b1; pf_ack_i = 1'b0; pf_instr_i = 32'h0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; id_ready_i = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_pc", pc_ff_o, 32'h8000_0000);
    chk("rst_valid", {31'h0, if2id_valid_o}, 32'h0);
    chk("rst_instr", if2id_instr_o, 32'h0);
    chk("rst_outpc", if2id_pc_o, 32'h0);
    chk("rst_comp", {31'h0, if2id_compressed_o}, 32'h0);
    chk("rst_req", {31'h0, instr_req_o}, 32'h0);
    chk("rst_clear", {31'h0, clear_o}, 32'h1);
    rst = 1'b0;

    // reset then fill
    step(1'b1, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    chk("fill_pc0", pc_ff_o, 32'h8000_0000);
    step(1'b1, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    chk("fill_pc1", pc_ff_o, 32'h8000_0000);
    step(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    chk("first_pc", if2id_pc_o, 32'h8000_0000);
    step(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    chk("second_pc", if2id_pc_o, 32'h8000_0004);
    step(1'b0, 1'b1, 32'h0000_0013, 1'b0, 32'h0, 1'b1);
    chk("third_pc", if2id_pc_o, 32'h8000_0008);

    // compressed stream
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h0000_4501, 1'b0, 32'h0, 1'b1);
      chk("c_flag", {31'h0, if2id_compressed_o}, 32'h1);
      chk("c_instr", if2id_instr_o, 32'h0000_4501);
      chk("c_pc", pc_ff_o, 32'h8000_000E + 32'(2 * i));
    end

    // misaligned 32-bit at ...02
    step(1'b1, 1'b0, 32'h00A0_0093, 1'b1, 32'h8000_0002, 1'b1);
    step(1'b0, 1'b0, 32'h00A0_0093, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h00A0_0093, 1'b0, 32'h0, 1'b1);
      chk("mis_hold", pc_ff_o, 32'h8000_0002);
    end
    step(1'b0, 1'b1, 32'h00A0_0093, 1'b0, 32'h0, 1'b1);
    chk("mis_outpc", if2id_pc_o, 32'h8000_0002);
    chk("mis_pc", pc_ff_o, 32'h8000_0006);

    // backpressure
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 32'h0010_0113, 1'b0, 32'h0, 1'b0);
      chk("bp_pc", pc_ff_o, 32'h8000_0006);
      chk("bp_outpc", if2id_pc_o, 32'h8000_0002);
      chk("bp_instr", if2id_instr_o, 32'h00A0_0093);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h0010_0113, 1'b0, 32'h0, 1'b1);
      chk("bp_resume", if2id_pc_o, 32'h8000_0006 + 32'(4 * i));
    end

    // redirect coincident with a take
    step(1'b0, 1'b1, 32'h0020_0193, 1'b1, 32'h8000_1235, 1'b1);
    chk("rd_pc", pc_ff_o, 32'h8000_1234);
    chk("rd_valid", {31'h0, if2id_valid_o}, 32'h0);
    step(1'b1, 1'b0, 32'h0020_0193, 1'b0, 32'h0, 1'b1);
    chk("rd_fill", {31'h0, instr_req_o}, 32'h1);

    // PC wrap
    step(1'b1, 1'b0, 32'h0030_0213, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 32'h0030_0213, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h0030_0213, 1'b0, 32'h0, 1'b1);
    chk("wrap_pc", pc_ff_o, 32'h0000_0000);
    chk("wrap_outpc", if2id_pc_o, 32'hFFFF_FFFC);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r   = $urandom;
      ins = $urandom;
      if (r[0]) ins[1:0] = 2'b11;
      step(r[3:1] == 3'd0, r[5:4] != 2'd0, ins, r[10:6] == 5'd0, $urandom, r[12:11] != 2'd0);
    end

    // asynchronous reset mid-operation
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc", pc_ff_o, 32'h8000_0000);
    chk("arst_valid", {31'h0, if2id_valid_o}, 32'h0);
    chk("arst_instr", if2id_instr_o, 32'h0);
    chk("arst_req", {31'h0, instr_req_o}, 32'h0);
    chk("arst_clear", {31'h0, clear_o}, 32'h1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      step(r[2:0] == 3'd0, r[3], $urandom, 1'b0, 32'h0, r[4] | r[5]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that consumes the halfword-aligning prefetch FIFO and drives its control. It owns the fetch PC, issues FIFO shift requests and clears, and detects compressed vs. 32-bit instructions to advance the PC by 2 or 4. It also registers the accepted instruction toward decode with a valid/ready handshake. It sits between the prefetch stage and the decode stage, and takes redirects from execute/CSR.

## Interface
- XLEN, 32, data/address width
- RESET_PC, 32'h8000_0000, fetch PC after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- pc_ff_o  out  XLEN  current fetch PC to prefetch
- instr_req_o  out  1  FIFO shift request to prefetch
- clear_o  out  1  FIFO clear to prefetch
- pf_stall_i  in  1  prefetch FIFO not yet valid (entry 1 empty)
- pf_ack_i  in  1  prefetch word at pc_ff_o is complete
- pf_instr_i  in  32  aligned instruction word from prefetch
- redirect_i  in  1  jump/branch/trap redirect
- redirect_pc_i  in  XLEN  redirect target
- id_ready_i  in  1  decode accepts output register
- if2id_valid_o  out  1  output register holds an instruction
- if2id_instr_o  out  32  instruction; compressed instructions are zero-extended in [31:16]
- if2id_pc_o  out  XLEN  PC of if2id_instr_o
- if2id_compressed_o  out  1  instruction is 16-bit

## Operation
- States: FILL, RUN. Reset enters FILL.
- Reset values:
  - pc_ff_o=RESET_PC, state=FILL.
  - if2id_valid_o=0; if2id_instr_o=0; if2id_pc_o=0; if2id_compressed_o=0.
  - instr_req_o=0; clear_o=1 while rst is high.
- clear_o = rst | redirect_i (combinational).
- Redirect priority: redirect_i overrides every other event in the same cycle.
  - pc_ff_o <= {redirect_pc_i[XLEN-1:1],1'b0}.
  - if2id_valid_o <= 0.
  - state <= FILL.
  - instr_req_o=0 that cycle.
  - Any concurrently accepted word is discarded.
- FILL:
  - instr_req_o = pf_stall_i.
  - When pf_stall_i=0, go to RUN.
  - No instruction is accepted in FILL.
- RUN:
  - take = pf_ack_i & ~pf_stall_i & (~if2id_valid_o | id_ready_i).
  - On take, the output register loads: instr = compressed ? {16'b0,pf_instr_i[15:0]} : pf_instr_i.
  - On take: if2id_pc_o <= pc_ff_o; if2id_compressed_o <= (pf_instr_i[1:0]!=2'b11); if2id_valid_o <= 1.
  - On take: pc_ff_o <= pc_ff_o + (compressed ? 2 : 4), modulo 2^XLEN (wraps to 0).
  - instr_req_o = take.
  - If ~take and id_ready_i, if2id_valid_o <= 0.
  - If pf_stall_i rises in RUN (FIFO underflow), state <= FILL with the PC held.
- Misaligned 32-bit instruction (pc_ff_o[1]=1): prefetch holds pf_ack_i=0 until both FIFO entries are valid. The stage waits in RUN with no PC change.
- Output register is held stable while if2id_valid_o=1 and id_ready_i=0.

## Timing
- Reset release to first if2id_valid_o: FIFO fill cycles (pf_stall_i high) + 1 cycle.
- Throughput: 1 instruction/cycle in RUN with pf_ack_i=1 and id_ready_i=1.
- Accept latency: take in cycle N gives if2id_valid_o=1 and the new pc_ff_o in cycle N+1.
- Redirect in cycle N:
  - clear_o=1 in cycle N only.
  - pc_ff_o = target in N+1; if2id_valid_o=0 in N+1.
  - FILL starts in N+1.
- Back-to-back redirects: each one reloads the PC. Only the last target survives.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous), regardless of state.

## Test plan
- Reset then fill:
  - Stimulus: rst 1→0, pf_stall_i=1 for 2 cycles then 0, pf_ack_i=1, pf_instr_i=32'h0000_0013.
  - Required: pc_ff_o=32'h8000_0000 during fill and instr_req_o=1 while stalled.
  - Required: first if2id_pc_o=32'h8000_0000; subsequent PCs 32'h8000_0004, 32'h8000_0008.
- Compressed stream:
  - Stimulus: pf_instr_i=32'h0000_4501.
  - Required: if2id_compressed_o=1, if2id_instr_o=32'h0000_4501, pc_ff_o advancing +2 per cycle (…00, …02, …04).
- Misaligned 32-bit at pc 32'h8000_0002, pf_ack_i=0 for 3 cycles:
  - Required: no take, pc_ff_o held, instr_req_o=0.
  - Required: on pf_ack_i=1, if2id_pc_o=32'h8000_0002 and pc_ff_o=32'h8000_0006.
- Backpressure: id_ready_i=0 for 4 cycles with valid data -> if2id_* frozen, instr_req_o=0, pc_ff_o constant; on release, streaming resumes with no lost or duplicated PC.
- Redirect during accept:
  - Stimulus: redirect_i=1, redirect_pc_i=32'h8000_1235 coincident with a take.
  - Required: clear_o=1 that cycle, next pc_ff_o=32'h8000_1234, if2id_valid_o=0, state FILL; the coincident word never appears on if2id.
- PC wrap: redirect to 32'hFFFF_FFFC, 32-bit instruction -> next pc_ff_o=32'h0000_0000.
